// File: rtl/ptw.sv
// ptw: Sv32 page-table walker; fetches L1/L0 PTEs and refills the TLB via re-lookup then write.
// Optional PTW_AD_CHECK_EN: fault on leaf PTEs whose accessed bit is clear.
module ptw (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        walk_req,
  input  logic [8:0]  walk_asid,
  input  logic [19:0] walk_vaddr,
  input  logic [16:0] satp_ppn,
  output logic        walk_ready,
  output logic        walk_done,
  output logic        walk_fault,
  output logic        mem_req,
  output logic [26:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        tlb_read_req,
  output logic [8:0]  tlb_read_asid,
  output logic [19:0] tlb_read_addr,
  output logic        tlb_write_req,
  output logic        tlb_write_super,
  output logic [10:0] tlb_write_tag,
  output logic [8:0]  tlb_write_asid,
  output logic [16:0] tlb_write_ppn,
  output logic [7:0]  tlb_write_flags
);
  typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, TLB_RD, TLB_WR, DONE} state_t;
  state_t r_state, w_next;
  logic [8:0]  r_asid;
  logic [19:0] r_vaddr;
  logic [16:0] r_satp, r_ppn;
  logic [7:0]  r_flags;
  logic        r_super, r_fault;
  logic        w_l1, w_rx, w_inv, w_leaf, w_mis, w_ad, w_fault, w_wr, w_unused;
  assign w_l1   = r_state == L1_WAIT;
  assign w_rx   = (w_l1 || r_state == L0_WAIT) && mem_rvalid;
  assign w_inv  = !mem_rdata[0] || (!mem_rdata[1] && mem_rdata[2]) || (|mem_rdata[31:27]);
  assign w_leaf = mem_rdata[1] || mem_rdata[3];
  assign w_mis  = |mem_rdata[19:10];
`ifdef PTW_AD_CHECK_EN
  assign w_ad = !mem_rdata[6];
`else
  assign w_ad = 1'b0;
`endif
  // A pointer is only legal at level 1; superpages must be 4 MiB aligned.
  assign w_fault  = w_inv || (w_leaf ? ((w_l1 && w_mis) || w_ad) : !w_l1);
  assign w_unused = ^mem_rdata[9:8];
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = walk_req ? L1_REQ : IDLE;
      L1_REQ:  w_next = mem_gnt ? L1_WAIT : L1_REQ;
      L1_WAIT: w_next = !mem_rvalid ? L1_WAIT : w_fault ? DONE : w_leaf ? TLB_RD : L0_REQ;
      L0_REQ:  w_next = mem_gnt ? L0_WAIT : L0_REQ;
      L0_WAIT: w_next = !mem_rvalid ? L0_WAIT : w_fault ? DONE : TLB_RD;
      TLB_RD:  w_next = TLB_WR;
      TLB_WR:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_asid  <= '0;
      r_vaddr <= '0;
      r_satp  <= '0;
      r_ppn   <= '0;
      r_flags <= '0;
      r_super <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && walk_req) begin
        r_asid  <= walk_asid;
        r_vaddr <= walk_vaddr;
        r_satp  <= satp_ppn;
        r_fault <= 1'b0;
      end
      if (w_rx) begin
        r_ppn   <= mem_rdata[26:10];
        r_flags <= mem_rdata[7:0];
        r_super <= w_l1;
        r_fault <= w_fault;
      end
    end
  end
  assign w_wr            = r_state == TLB_WR;
  assign walk_ready      = r_state == IDLE;
  assign walk_done       = r_state == DONE;
  assign walk_fault      = walk_done && r_fault;
  assign mem_req         = r_state == L1_REQ || r_state == L0_REQ;
  assign mem_addr        = r_state == L1_REQ ? {r_satp, r_vaddr[19:10]} :
                           r_state == L0_REQ ? {r_ppn, r_vaddr[9:0]} : '0;
  assign tlb_read_req    = r_state == TLB_RD;
  assign tlb_read_asid   = r_asid;
  assign tlb_read_addr   = r_vaddr;
  assign tlb_write_req   = w_wr;
  assign tlb_write_super = w_wr && r_super;
  assign tlb_write_tag   = w_wr ? r_vaddr[19:9] : '0;
  assign tlb_write_asid  = w_wr ? r_asid : '0;
  assign tlb_write_ppn   = !w_wr ? '0 : r_super ? {r_ppn[16:10], 10'd0} : r_ppn;
  assign tlb_write_flags = w_wr ? r_flags : '0;
endmodule

// File: tb/tb_ptw.sv
// tb_ptw: directed self-checking bench for the Sv32 page-table walker.
module tb_ptw;
  logic        clk, reset_n, walk_req, mem_gnt, mem_rvalid;
  logic [8:0]  walk_asid;
  logic [19:0] walk_vaddr;
  logic [16:0] satp_ppn;
  logic [31:0] mem_rdata;
  logic        walk_ready, walk_done, walk_fault, mem_req, tlb_read_req, tlb_write_req, tlb_write_super;
  logic [26:0] mem_addr;
  logic [8:0]  tlb_read_asid, tlb_write_asid;
  logic [19:0] tlb_read_addr;
  logic [10:0] tlb_write_tag;
  logic [16:0] tlb_write_ppn;
  logic [7:0]  tlb_write_flags;
  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0, lat = 0, n_rd = 0, n_wr = 0, n_done = 0;
  logic prev_rd = 0, wr_after_rd = 0, c_fault = 0, c_super = 0;
  logic [10:0] c_tag;
  logic [8:0]  c_asid, c_rasid;
  logic [19:0] c_raddr;
  logic [16:0] c_ppn;
  logic [7:0]  c_flags;

  ptw dut (
    .clk(clk), .reset_n(reset_n), .walk_req(walk_req), .walk_asid(walk_asid),
    .walk_vaddr(walk_vaddr), .satp_ppn(satp_ppn), .walk_ready(walk_ready),
    .walk_done(walk_done), .walk_fault(walk_fault), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .tlb_read_req(tlb_read_req), .tlb_read_asid(tlb_read_asid),
    .tlb_read_addr(tlb_read_addr), .tlb_write_req(tlb_write_req),
    .tlb_write_super(tlb_write_super), .tlb_write_tag(tlb_write_tag),
    .tlb_write_asid(tlb_write_asid), .tlb_write_ppn(tlb_write_ppn),
    .tlb_write_flags(tlb_write_flags)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc++;
    if (tlb_read_req) begin
      n_rd++;
      c_raddr = tlb_read_addr;
      c_rasid = tlb_read_asid;
    end
    if (tlb_write_req) begin
      n_wr++;
      wr_after_rd = prev_rd;
      c_super = tlb_write_super;
      c_tag = tlb_write_tag;
      c_asid = tlb_write_asid;
      c_ppn = tlb_write_ppn;
      c_flags = tlb_write_flags;
    end
    prev_rd = tlb_read_req;
    if (walk_done) begin
      n_done++;
      c_fault = walk_fault;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [8:0] a, input logic [19:0] v, input logic [16:0] s);
    n_rd = 0; n_wr = 0; n_done = 0; wr_after_rd = 0;
    walk_req = 1; walk_asid = a; walk_vaddr = v; satp_ppn = s;
    t0 = cyc;
    @(negedge clk);
    walk_req = 0;
  endtask

  task automatic serve(input string tag, input logic [26:0] addr, input logic [31:0] d,
                       input int gd, input int rd);
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    for (int i = 0; i < gd; i++) begin
      chk({tag, "_addr_stall"}, 32'(mem_addr), 32'(addr));
      @(negedge clk);
    end
    chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    for (int i = 0; i < rd; i++) begin
      chk({tag, "_req_drop"}, 32'(mem_req), 32'd0);
      @(negedge clk);
    end
    mem_rdata = d; mem_rvalid = 1;
    @(negedge clk);
    mem_rvalid = 0;
  endtask

  task automatic finish_walk(input string tag, input logic fault);
    int n = 0;
    while (!walk_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - t0 + 1;
    chk({tag, "_done"}, 32'(walk_done), 32'd1);
    chk({tag, "_fault"}, 32'(walk_fault), 32'(fault));
    @(negedge clk);
    chk({tag, "_ndone"}, 32'(n_done), 32'd1);
    chk({tag, "_idle"}, 32'(walk_ready), 32'd1);
    if (fault) begin
      chk({tag, "_nrd"}, 32'(n_rd), 32'd0);
      chk({tag, "_nwr"}, 32'(n_wr), 32'd0);
    end else begin
      chk({tag, "_nrd"}, 32'(n_rd), 32'd1);
      chk({tag, "_nwr"}, 32'(n_wr), 32'd1);
      chk({tag, "_rd_then_wr"}, 32'(wr_after_rd), 32'd1);
    end
  endtask

  task automatic chk_refill(input string tag, input logic sup, input logic [16:0] ppn,
                            input logic [7:0] fl, input logic [10:0] tg, input logic [8:0] a,
                            input logic [19:0] v);
    chk({tag, "_super"}, 32'(c_super), 32'(sup));
    chk({tag, "_ppn"}, 32'(c_ppn), 32'(ppn));
    chk({tag, "_flags"}, 32'(c_flags), 32'(fl));
    chk({tag, "_tag"}, 32'(c_tag), 32'(tg));
    chk({tag, "_wasid"}, 32'(c_asid), 32'(a));
    chk({tag, "_raddr"}, 32'(c_raddr), 32'(v));
    chk({tag, "_rasid"}, 32'(c_rasid), 32'(a));
  endtask

  initial begin
    reset_n = 0; walk_req = 0; walk_asid = 0; walk_vaddr = 0; satp_ppn = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    @(negedge clk);
    chk("rst_ready", 32'(walk_ready), 32'd1);
    chk("rst_done", 32'(walk_done), 32'd0);
    chk("rst_memreq", 32'(mem_req), 32'd0);
    chk("rst_memaddr", 32'(mem_addr), 32'd0);
    chk("rst_tlbrd", 32'({tlb_read_req, tlb_read_asid, tlb_read_addr}), 32'd0);
    chk("rst_tlbwr", 32'({tlb_write_req, tlb_write_super, tlb_write_tag}), 32'd0);
    chk("rst_wfields", 32'({tlb_write_asid, tlb_write_ppn}), 32'd0);
    chk("rst_flags", 32'(tlb_write_flags), 32'd0);
    reset_n = 1;
    @(negedge clk);

    // 4 KiB walk, zero-wait memory
    start(9'h1A5, 20'h12345, 17'h00010);
    serve("k4_l1", 27'h0004048, 32'h00004001, 0, 0);
    serve("k4_l0", 27'h0004345, 32'h000123CF, 0, 0);
    finish_walk("k4", 1'b0);
    chk("k4_latency", 32'(lat), 32'd8);
    chk_refill("k4", 1'b0, 17'h00048, 8'hCF, 11'h091, 9'h1A5, 20'h12345);

    // Superpage, single memory read
    start(9'h003, 20'h12345, 17'h00010);
    serve("sp_l1", 27'h0004048, 32'h00C000CF, 0, 0);
    finish_walk("sp", 1'b0);
    chk("sp_latency", 32'(lat), 32'd6);
    chk_refill("sp", 1'b1, 17'h03000, 8'hCF, 11'h091, 9'h003, 20'h12345);

    start(9'h011, 20'hABCDE, 17'h00020);
    serve("inv_l1", 27'h00082AF, 32'h00000000, 0, 0);
    finish_walk("inv", 1'b1);

    start(9'h011, 20'h12345, 17'h00010);
    serve("mis_l1", 27'h0004048, 32'h00C004CF, 0, 0);
    finish_walk("mis", 1'b1);

    start(9'h011, 20'h12345, 17'h00010);
    serve("nl_l1", 27'h0004048, 32'h00004001, 0, 0);
    serve("nl_l0", 27'h0004345, 32'h00004001, 0, 0);
    finish_walk("nonleaf", 1'b1);

    // Reserved upper PTE bits make the PTE invalid
    start(9'h011, 20'h12345, 17'h00010);
    serve("rsv_l1", 27'h0004048, 32'h080000CF, 0, 0);
    finish_walk("rsv", 1'b1);

    // Leaf with A=0
    start(9'h022, 20'h12345, 17'h00010);
    serve("ad_l1", 27'h0004048, 32'h00004001, 0, 0);
    serve("ad_l0", 27'h0004345, 32'h0001238F, 0, 0);
`ifdef PTW_AD_CHECK_EN
    finish_walk("ad", 1'b1);
`else
    finish_walk("ad", 1'b0);
    chk_refill("ad", 1'b0, 17'h00048, 8'h8F, 11'h091, 9'h022, 20'h12345);
`endif

    // Backpressure; a second walk_req mid-walk must be dropped
    start(9'h1A5, 20'h12345, 17'h00010);
    walk_req = 1; walk_vaddr = 20'hFFFFF; satp_ppn = 17'h1FFFF;
    chk("bp_busy", 32'(walk_ready), 32'd0);
    @(negedge clk);
    walk_req = 0;
    serve("bp_l1", 27'h0004048, 32'h00004001, 5, 3);
    serve("bp_l0", 27'h0004345, 32'h000123CF, 5, 3);
    finish_walk("bp", 1'b0);
    chk_refill("bp", 1'b0, 17'h00048, 8'hCF, 11'h091, 9'h1A5, 20'h12345);
    repeat (3) @(negedge clk);
    chk("bp_not_queued", 32'(mem_req), 32'd0);
    chk("bp_ndone", 32'(n_done), 32'd1);

    // Reset while waiting for L1 data
    start(9'h1A5, 20'h12345, 17'h00010);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    reset_n = 0;
    #1;
    chk("mr_ready", 32'(walk_ready), 32'd1);
    chk("mr_memreq", 32'(mem_req), 32'd0);
    chk("mr_raddr", 32'(tlb_read_addr), 32'd0);
    chk("mr_rasid", 32'(tlb_read_asid), 32'd0);
    @(negedge clk);
    reset_n = 1;
    mem_rdata = 32'h00C000CF; mem_rvalid = 1;
    @(negedge clk);
    mem_rvalid = 0;
    repeat (6) @(negedge clk);
    chk("mr_ndone", 32'(n_done), 32'd0);
    chk("mr_nrd", 32'(n_rd), 32'd0);
    chk("mr_nwr", 32'(n_wr), 32'd0);
    chk("mr_idle", 32'({walk_ready, mem_req}), 32'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
